// File: rtl/eth_wb_mem_responder.sv
// WISHBONE B3 slave SRAM model answering the ethmac DMA master port, with
// programmable wait states, linear/wrap bursts, protocol checking and a backdoor port.
//
// state | meaning
// IDLE  | waiting for cyc&stb, decodes address/sel
// WAIT  | counting down wait states before first ack
// ACK   | first (or only) beat acked, write committed on this edge
// BURST | zero-wait beats, incoming address checked against prediction
// ERR   | single-cycle error response
module eth_wb_mem_responder #(
  parameter int          MEM_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       m_wb_adr_o,
  input  logic [3:0]        m_wb_sel_o,
  input  logic              m_wb_we_o,
  input  logic [31:0]       m_wb_dat_o,
  input  logic              m_wb_cyc_o,
  input  logic              m_wb_stb_o,
  input  logic [2:0]        m_wb_cti_o,
  input  logic [1:0]        m_wb_bte_o,
  output logic [31:0]       m_wb_dat_i,
  output logic              m_wb_ack_i,
  output logic              m_wb_err_i,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_adr,
  input  logic [31:0]       bd_wdat,
  output logic [31:0]       bd_rdat,
  output logic              proto_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_BURST, S_ERR} state_t;

  localparam logic [32:0] MEM_BYTES = 33'd1 << (MEM_AW + 2);
  localparam logic [2:0]  CTI_INCR  = 3'b010;

  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  state_t            state, state_nxt;
  logic [31:0]       pred_adr, next_pred_adr;
  logic [3:0]        wcnt;
  logic              req, req_bad, adr_in_range, pred_in_range, beat_match;
  logic [31:0]       adr_off, pred_off;
  logic [MEM_AW-1:0] cur_idx, wrap_mask, wrap_idx;
  logic              ack, err, pred_load, pred_adv, wcnt_load, wcnt_dec;

  assign req           = m_wb_cyc_o & m_wb_stb_o;
  assign adr_off       = m_wb_adr_o - BASE_ADDR;
  assign pred_off      = pred_adr - BASE_ADDR;
  assign adr_in_range  = {1'b0, adr_off} < MEM_BYTES;
  assign pred_in_range = {1'b0, pred_off} < MEM_BYTES;
  assign req_bad       = (m_wb_adr_o[1:0] != 2'b00) || (m_wb_sel_o == 4'b0000) || !adr_in_range;
  assign beat_match    = (m_wb_adr_o == pred_adr) && pred_in_range;
  assign cur_idx       = pred_off[MEM_AW+1:2];

  // Wrap bursts only step the low index bits; linear keeps full 32-bit address so overrun is caught.
  always_comb begin
    wrap_mask = '0;
    case (m_wb_bte_o)
      2'b01:   wrap_mask = MEM_AW'(3);
      2'b10:   wrap_mask = MEM_AW'(7);
      2'b11:   wrap_mask = MEM_AW'(15);
      default: wrap_mask = '0;
    endcase
    wrap_idx = (cur_idx & ~wrap_mask) | ((cur_idx + 1'b1) & wrap_mask);
    if (m_wb_bte_o == 2'b00)
      next_pred_adr = pred_adr + 32'd4;
    else
      next_pred_adr = BASE_ADDR + 32'({wrap_idx, 2'b00});
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    err       = 1'b0;
    pred_load = 1'b0;
    pred_adv  = 1'b0;
    wcnt_load = 1'b0;
    wcnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (req_bad) begin
            state_nxt = S_ERR;
          end else begin
            pred_load = 1'b1;
            wcnt_load = 1'b1;
            state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!m_wb_cyc_o)      state_nxt = S_IDLE;
        else if (wcnt == 4'd0) state_nxt = S_ACK;
        else                  wcnt_dec  = 1'b1;
      end
      S_ACK: begin
        if (!m_wb_cyc_o) begin
          state_nxt = S_IDLE;
        end else if (m_wb_stb_o) begin
          ack = 1'b1;
          if (m_wb_cti_o == CTI_INCR) begin
            pred_adv  = 1'b1;
            state_nxt = S_BURST;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_BURST: begin
        if (!m_wb_cyc_o) begin
          state_nxt = S_IDLE;
        end else if (m_wb_stb_o) begin
          if (beat_match) begin
            ack = 1'b1;
            if (m_wb_cti_o == CTI_INCR) pred_adv  = 1'b1;
            else                        state_nxt = S_IDLE;
          end else begin
            err       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_ERR: begin
        err       = req;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= S_IDLE;
      pred_adr  <= '0;
      wcnt      <= '0;
      proto_err <= 1'b0;
      bd_rdat   <= '0;
    end else begin
      state <= state_nxt;
      if (pred_load)     pred_adr <= m_wb_adr_o;
      else if (pred_adv) pred_adr <= next_pred_adr;
      if (wcnt_load)     wcnt <= 4'(WAIT_STATES - 1);
      else if (wcnt_dec) wcnt <= wcnt - 4'd1;
      if (err)           proto_err <= 1'b1;
      bd_rdat <= mem[bd_adr];
    end
  end

  // Bus byte writes are applied after the backdoor word so the bus wins on a collision.
  always_ff @(posedge wb_clk_i) begin
    if (bd_we) mem[bd_adr] <= bd_wdat;
    if (ack && m_wb_we_o) begin
      for (int b = 0; b < 4; b++)
        if (m_wb_sel_o[b]) mem[cur_idx][8*b +: 8] <= m_wb_dat_o[8*b +: 8];
    end
  end

  assign m_wb_ack_i = ack;
  assign m_wb_err_i = err;
  assign m_wb_dat_i = ack ? mem[cur_idx] : 32'h0;

endmodule

// File: tb/tb_eth_wb_mem_responder.sv
// Directed self-checking bench for eth_wb_mem_responder (MEM_AW=10, BASE=0, WAIT_STATES=1).
module tb_eth_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_w, dat_r, bd_wdat, bd_rdat;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, bd_we, proto_err;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [9:0]  bd_adr;
  int          checks = 0;
  int          errors = 0;

  eth_wb_mem_responder #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m_wb_adr_o(adr), .m_wb_sel_o(sel), .m_wb_we_o(we), .m_wb_dat_o(dat_w),
    .m_wb_cyc_o(cyc), .m_wb_stb_o(stb), .m_wb_cti_o(cti), .m_wb_bte_o(bte),
    .m_wb_dat_i(dat_r), .m_wb_ack_i(ack), .m_wb_err_i(err),
    .bd_we(bd_we), .bd_adr(bd_adr), .bd_wdat(bd_wdat), .bd_rdat(bd_rdat),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] s, input logic w,
                       input logic [31:0] d, input logic [2:0] ct, input logic [1:0] bt);
    cyc = 1'b1; stb = 1'b1; adr = a; sel = s; we = w; dat_w = d; cti = ct; bte = bt;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00; adr = '0; sel = '0; dat_w = '0;
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] val);
    bd_we = 1'b1; bd_adr = idx; bd_wdat = val;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [9:0] idx, output logic [31:0] val);
    bd_adr = idx;
    tick();
    val = bd_rdat;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bd_we = 1'b0; bd_adr = '0; bd_wdat = '0;
    bus_idle();
    #2;
    checks++; if (ack !== 1'b0)        begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (dat_r !== 32'h0)     begin errors++; $display("FAIL rst_dat got %h exp 0", dat_r); end
    checks++; if (bd_rdat !== 32'h0)   begin errors++; $display("FAIL rst_bd_rdat got %h exp 0", bd_rdat); end
    checks++; if (proto_err !== 1'b0)  begin errors++; $display("FAIL rst_proto_err got %b exp 0", proto_err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classic_read();
    bd_write(10'd5, 32'hDEAD_BEEF);
    drive(32'h14, 4'hF, 1'b0, 32'h0, 3'b000, 2'b00);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL cr_ack_c0 got %b exp 0", ack); end
    tick(); @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL cr_ack_c1 got %b exp 0", ack); end
    tick(); @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL cr_ack_c2 got %b exp 1", ack); end
    checks++; if (dat_r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cr_dat got %h exp deadbeef", dat_r); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL cr_err got %b exp 0", err); end
    tick(); bus_idle(); @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL cr_ack_c3 got %b exp 0", ack); end
  endtask

  task automatic test_byte_write();
    logic [31:0] v;
    bd_write(10'd6, 32'h0);
    drive(32'h18, 4'b0100, 1'b1, 32'h00AB_0000, 3'b000, 2'b00);
    tick(); tick(); @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_ack got %b exp 1", ack); end
    tick(); bus_idle();
    bd_read(10'd6, v);
    checks++; if (v !== 32'h00AB_0000) begin errors++; $display("FAIL bw_word6 got %h exp 00ab0000", v); end
    bd_write(10'd7, 32'h1122_3344);
    drive(32'h1C, 4'b0001, 1'b1, 32'hFFFF_FFEE, 3'b000, 2'b00);
    tick(); tick(); tick(); bus_idle();
    bd_read(10'd7, v);
    checks++; if (v !== 32'h1122_33EE) begin errors++; $display("FAIL bw_word7 got %h exp 112233ee", v); end
  endtask

  task automatic test_incr_burst();
    for (int i = 16; i < 20; i++) bd_write(10'(i), 32'hA5A5_0000 | 32'(i));
    drive(32'h40, 4'hF, 1'b0, 32'h0, 3'b010, 2'b00);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ib_ack_c0 got %b exp 0", ack); end
    tick(); @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ib_ack_c1 got %b exp 0", ack); end
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drive(32'h40 + 32'(4*k), 4'hF, 1'b0, 32'h0, (k == 3) ? 3'b111 : 3'b010, 2'b00);
      @(negedge clk);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ib_ack_beat%0d got %b exp 1", k, ack); end
      checks++; if (dat_r !== (32'hA5A5_0010 + 32'(k)))
        begin errors++; $display("FAIL ib_dat_beat%0d got %h exp %h", k, dat_r, 32'hA5A5_0010 + 32'(k)); end
      tick();
    end
    bus_idle(); @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ib_ack_end got %b exp 0", ack); end
  endtask

  task automatic test_wrap_burst();
    logic [31:0] wadr [4] = '{32'h48, 32'h4C, 32'h40, 32'h44};
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wb_proto_pre got %b exp 0", proto_err); end
    drive(wadr[0], 4'hF, 1'b0, 32'h0, 3'b010, 2'b01);
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drive(wadr[k], 4'hF, 1'b0, 32'h0, (k == 3) ? 3'b111 : 3'b010, 2'b01);
      @(negedge clk);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wb_ack_beat%0d got %b exp 1", k, ack); end
      checks++; if (dat_r !== (32'hA5A5_0000 | (wadr[k] >> 2)))
        begin errors++; $display("FAIL wb_dat_beat%0d got %h exp %h", k, dat_r, 32'hA5A5_0000 | (wadr[k] >> 2)); end
      tick();
    end
    bus_idle(); tick();
    drive(32'h48, 4'hF, 1'b0, 32'h0, 3'b010, 2'b01);
    tick(); tick(); tick();
    drive(32'h4C, 4'hF, 1'b0, 32'h0, 3'b010, 2'b01);
    tick();
    drive(32'h50, 4'hF, 1'b0, 32'h0, 3'b010, 2'b01);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wb_err_bad got %b exp 1", err); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wb_ack_bad got %b exp 0", ack); end
    tick(); bus_idle(); @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wb_err_after got %b exp 0", err); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wb_proto_post got %b exp 1", proto_err); end
    tick();
  endtask

  task automatic test_bad_access();
    logic [31:0] badr [3] = '{32'h1000, 32'h0000_0002, 32'h0};
    logic [3:0]  bsel [3] = '{4'hF, 4'hF, 4'h0};
    logic [31:0] v;
    bd_write(10'd0, 32'h5555_AAAA);
    for (int i = 0; i < 3; i++) begin
      drive(badr[i], bsel[i], 1'b1, 32'hFFFF_FFFF, 3'b000, 2'b00);
      tick(); @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ba_err_%0d got %b exp 1", i, err); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ba_ack_%0d got %b exp 0", i, ack); end
      tick(); bus_idle(); @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ba_err_drop_%0d got %b exp 0", i, err); end
      tick();
    end
    bd_read(10'd0, v);
    checks++; if (v !== 32'h5555_AAAA) begin errors++; $display("FAIL ba_word0 got %h exp 5555aaaa", v); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] v;
    bd_write(10'd32, 32'h0);
    bd_write(10'd33, 32'h3333_3333);
    drive(32'h80, 4'hF, 1'b1, 32'hCAFE_0001, 3'b010, 2'b00);
    tick(); tick(); @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rb_ack_beat1 got %b exp 1", ack); end
    tick();
    drive(32'h84, 4'hF, 1'b1, 32'hCAFE_0002, 3'b010, 2'b00);
    #2;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rb_ack_beat2 got %b exp 1", ack); end
    rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rb_ack_rst got %b exp 0", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rb_err_rst got %b exp 0", err); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rb_proto_rst got %b exp 0", proto_err); end
    bus_idle();
    tick(); tick();
    rst_n = 1'b1;
    bd_read(10'd32, v);
    checks++; if (v !== 32'hCAFE_0001) begin errors++; $display("FAIL rb_word32 got %h exp cafe0001", v); end
    bd_read(10'd33, v);
    checks++; if (v !== 32'h3333_3333) begin errors++; $display("FAIL rb_word33 got %h exp 33333333", v); end
  endtask

  initial begin
    test_reset();
    test_classic_read();
    test_byte_write();
    test_incr_burst();
    test_wrap_burst();
    test_bad_access();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
